branch_target_predictor: RTL and testbench
==========================================

# branch_target_predictor

Parametrised, sequential branch predictor for the fetch stage. It replaces the purely combinational next-PC preparation with three stored structures: a direct-mapped branch target buffer (BTB), per-entry 2-bit saturating counters, and a return address stack (RAS) with mispredict recovery. The block is looked up at pre-fetch with the PF PC and returns a registered prediction aligned with IF. It is trained from EX with the resolved branch outcome.

## Interface
Parameters:
- ENTRIES, 64: BTB entry count; power of 2, ≥4; IDX_W = log2(ENTRIES).
- TAG_W, 8: tag width taken from PC above the index.
- RAS_DEPTH, 8: RAS entry count; power of 2, ≥2.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous, active-low reset.
- pf_valid  in  1  lookup request.
- pf_pc  in  32  lookup PC (word aligned).
- stall  in  1  front end stalled; holds the outputs.
- flush  in  1  kill the prediction currently being produced.
- bp_valid  out  1  prediction valid (IF stage).
- bp_taken  out  1  predict taken.
- bp_target  out  32  predicted target; 0 when not taken.
- upd_valid  in  1  EX resolved a branch or jump.
- upd_pc  in  32  PC of the branch.
- upd_type  in  2  00 conditional, 01 direct jump, 10 call (JAL/JALR), 11 return (JR $31).
- upd_taken  in  1  actual direction.
- upd_target  in  32  actual target.
- upd_mispredict  in  1  EX detected a misprediction; recover the RAS.

## Operation
- Index is pc[IDX_W+1:2]. Tag is pc[IDX_W+TAG_W+1:IDX_W+2]. A hit requires `valid & tag match`.
- Each entry holds valid, tag, target[31:2], type[1:0] and ctr[1:0].
- Prediction on a hit, by type:
  - conditional: taken = ctr[1], target = stored target.
  - jump or call: taken = 1.
  - return: taken = RAS non-empty, target = RAS top.
- On a miss: taken = 0, target = 0.
- Speculative RAS operations happen at lookup, only when pf_valid & ~stall & hit:
  - a call pushes pf_pc+8 (the delay slot is skipped).
  - a return pops.
- RAS boundaries:
  - push when full overwrites the oldest entry (circular); count saturates at RAS_DEPTH.
  - pop when empty leaves the stack unchanged.
- A committed copy of the pointer and count is advanced by upd_valid for call and return types.
  - When upd_mispredict is set, the speculative pointer and count are loaded from the committed copy after this update's own push or pop is applied.
  - Stack contents are not restored. Entries overwritten on the wrong path stay corrupted, and this is accepted.
- Update on upd_valid:
  - hit: the counter saturates toward upd_taken (00 to 11). If upd_taken, target and type are rewritten.
  - miss with upd_taken: allocate the entry. ctr = 10 for conditional, 11 otherwise.
  - miss with not taken: no change.
- A simultaneous lookup and update to the same index: the lookup sees the pre-update contents (no bypass).

## Timing
- Lookup latency is 1 cycle: pf_valid at cycle N gives bp_* at N+1.
- stall=1 holds bp_* and suppresses all lookup-side effects.
- flush=1 at N gives bp_valid=0 at N+1. flush has priority over pf_valid, and its RAS effect is suppressed.
- An update written at cycle N is visible to a lookup issued at N+1.
- Reset (asynchronous, at any time, including mid-operation):
  - all valid bits = 0, all ctr = 01.
  - RAS pointers and counts = 0.
  - bp_valid = 0, bp_taken = 0, bp_target = 0.
- Storage is flops with no SRAM handshake, so every update completes in 1 cycle.

## Structure
- MacroDef.v gains the BR_COND, BR_JUMP, BR_CALL and BR_RET type codes and the counter encodings. It also gains RET_OFFSET (8).
- Sub-module `ras_stack`, parametrised by RAS_DEPTH:
  - ports: push, pop, push_data, top, empty, recover, and the committed push/pop.
  - internals: speculative and committed pointers plus counts.
- The top level holds the BTB arrays, the index/tag logic, the update FSM-free datapath and the output registers.

## Test plan
- Reset, then look up 0xBFC0_0000 → bp_valid=1, bp_taken=0, bp_target=0.
- Update a conditional at 0xBFC0_0010 with taken and target 0xBFC0_0100, then look up 0xBFC0_0010 → taken, target 0xBFC0_0100. Two not-taken updates → ctr 00 → predict not taken.
- Look up a call at 0xBFC0_0020 (after training) → RAS top 0xBFC0_0028. Then look up a trained return → taken, target 0xBFC0_0028, RAS empty afterwards.
- Do 9 pushes with RAS_DEPTH=8 → count stays 8 and the oldest entry is overwritten. 9 pops → the last pop returns taken=0.
- Do a speculative push from a wrong path, then upd_mispredict with a conditional type → the speculative count equals the committed count.
- Drive the following conditions in turn:
  - same-cycle update and lookup to the same index → the lookup returns the old prediction.
  - stall for 3 cycles → bp_* constant.
  - flush → bp_valid=0 next cycle.
  - aresetn pulse mid-stream → all outputs 0 immediately.

Source files
------------

// File: rtl/branch_target_predictor_pkg.sv
// rtl/branch_target_predictor_pkg.sv - branch type codes, counter encodings and helpers
package branch_target_predictor_pkg;

    typedef enum logic [1:0] {
        BR_COND = 2'b00,
        BR_JUMP = 2'b01,
        BR_CALL = 2'b10,
        BR_RET  = 2'b11
    } br_type_e;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    // A call returns past its delay slot
    localparam logic [31:0] RET_OFFSET = 32'd8;

    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
        end
        return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/branch_target_predictor_if.sv
// rtl/branch_target_predictor_if.sv - lookup, prediction and training signals
interface branch_target_predictor_if;

    logic        pf_valid;
    logic [31:0] pf_pc;
    logic        stall;
    logic        flush;
    logic        bp_valid;
    logic        bp_taken;
    logic [31:0] bp_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [1:0]  upd_type;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_mispredict;

    modport master (
        output pf_valid, pf_pc, stall, flush,
        output upd_valid, upd_pc, upd_type, upd_taken, upd_target, upd_mispredict,
        input  bp_valid, bp_taken, bp_target
    );

    modport slave (
        input  pf_valid, pf_pc, stall, flush,
        input  upd_valid, upd_pc, upd_type, upd_taken, upd_target, upd_mispredict,
        output bp_valid, bp_taken, bp_target
    );

endinterface

// File: rtl/branch_target_predictor_ras_stack.sv
// rtl/branch_target_predictor_ras_stack.sv - circular return address stack with committed-pointer recovery
module ras_stack #(
    parameter int RAS_DEPTH = 8
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        push,
    input  logic        pop,
    input  logic [31:0] push_data,
    input  logic        commit_push,
    input  logic        commit_pop,
    input  logic        recover,
    output logic [31:0] top,
    output logic        empty
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(RAS_DEPTH);

    logic [31:2]      mem_q [RAS_DEPTH];
    logic [31:2]      mem_d [RAS_DEPTH];
    logic [PTR_W-1:0] sp_q, sp_d, csp_q, csp_d;
    logic [PTR_W:0]   cnt_q, cnt_d, ccnt_q, ccnt_d;
    logic [PTR_W-1:0] top_idx;
    logic             unused_ok;

    assign top_idx   = sp_q - 1'b1;
    assign top       = {mem_q[top_idx], 2'b00};
    assign empty     = (cnt_q == '0);
    assign unused_ok = ^push_data[1:0];

    always_comb begin
        mem_d  = mem_q;
        sp_d   = sp_q;
        cnt_d  = cnt_q;
        csp_d  = csp_q;
        ccnt_d = ccnt_q;

        // Full pushes wrap onto the oldest slot; the count just saturates
        if (push) begin
            mem_d[sp_q] = push_data[31:2];
            sp_d        = sp_q + 1'b1;
            if (cnt_q != FULL_CNT) cnt_d = cnt_q + 1'b1;
        end else if (pop && cnt_q != '0) begin
            sp_d  = sp_q - 1'b1;
            cnt_d = cnt_q - 1'b1;
        end

        if (commit_push) begin
            csp_d = csp_q + 1'b1;
            if (ccnt_q != FULL_CNT) ccnt_d = ccnt_q + 1'b1;
        end else if (commit_pop && ccnt_q != '0) begin
            csp_d  = csp_q - 1'b1;
            ccnt_d = ccnt_q - 1'b1;
        end

        // Only the pointers rewind; wrong-path overwrites stay in mem
        if (recover) begin
            sp_d  = csp_d;
            cnt_d = ccnt_d;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            mem_q  <= '{default: '0};
            sp_q   <= '0;
            cnt_q  <= '0;
            csp_q  <= '0;
            ccnt_q <= '0;
        end else begin
            mem_q  <= mem_d;
            sp_q   <= sp_d;
            cnt_q  <= cnt_d;
            csp_q  <= csp_d;
            ccnt_q <= ccnt_d;
        end
    end

endmodule

// File: rtl/branch_target_predictor.sv
// rtl/branch_target_predictor.sv - BTB with 2-bit counters and RAS, registered prediction into IF
module branch_target_predictor #(
    parameter int ENTRIES   = 64,
    parameter int TAG_W     = 8,
    parameter int RAS_DEPTH = 8
) (
    input logic                       aclk,
    input logic                       aresetn,
    branch_target_predictor_if.slave  bus
);

    import branch_target_predictor_pkg::*;

    localparam int IDX_W = $clog2(ENTRIES);

    logic             valid_q [ENTRIES];
    logic             valid_d [ENTRIES];
    logic [TAG_W-1:0] tag_q   [ENTRIES];
    logic [TAG_W-1:0] tag_d   [ENTRIES];
    logic [31:2]      tgt_q   [ENTRIES];
    logic [31:2]      tgt_d   [ENTRIES];
    br_type_e         type_q  [ENTRIES];
    br_type_e         type_d  [ENTRIES];
    logic [1:0]       ctr_q   [ENTRIES];
    logic [1:0]       ctr_d   [ENTRIES];

    logic             bp_valid_q, bp_valid_d;
    logic             bp_taken_q, bp_taken_d;
    logic [31:0]      bp_target_q, bp_target_d;

    logic [IDX_W-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0] lk_tag, up_tag;
    logic             lk_hit, up_hit, lk_go;
    br_type_e         lk_type, up_type;
    logic             pred_taken;
    logic [31:0]      pred_target;
    logic             ras_push, ras_pop, ras_empty;
    logic [31:0]      ras_top;
    logic             unused_ok;

    assign lk_idx  = bus.pf_pc[IDX_W+1:2];
    assign lk_tag  = bus.pf_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign lk_hit  = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign lk_type = type_q[lk_idx];
    assign up_idx  = bus.upd_pc[IDX_W+1:2];
    assign up_tag  = bus.upd_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign up_hit  = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    assign up_type = br_type_e'(bus.upd_type);

    assign lk_go    = bus.pf_valid && !bus.stall && !bus.flush;
    assign ras_push = lk_go && lk_hit && (lk_type == BR_CALL);
    assign ras_pop  = lk_go && lk_hit && (lk_type == BR_RET);

    assign unused_ok = ^{bus.pf_pc[31:IDX_W+TAG_W+2], bus.pf_pc[1:0],
                         bus.upd_pc[31:IDX_W+TAG_W+2], bus.upd_pc[1:0],
                         bus.upd_target[1:0]};

    ras_stack #(.RAS_DEPTH(RAS_DEPTH)) u_ras (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .push        (ras_push),
        .pop         (ras_pop),
        .push_data   (bus.pf_pc + RET_OFFSET),
        .commit_push (bus.upd_valid && up_type == BR_CALL),
        .commit_pop  (bus.upd_valid && up_type == BR_RET),
        .recover     (bus.upd_valid && bus.upd_mispredict),
        .top         (ras_top),
        .empty       (ras_empty)
    );

    always_comb begin
        pred_taken  = 1'b0;
        pred_target = '0;
        if (lk_hit) begin
            unique case (lk_type)
                BR_COND: begin
                    pred_taken  = ctr_q[lk_idx][1];
                    pred_target = {tgt_q[lk_idx], 2'b00};
                end
                BR_JUMP, BR_CALL: begin
                    pred_taken  = 1'b1;
                    pred_target = {tgt_q[lk_idx], 2'b00};
                end
                BR_RET: begin
                    pred_taken  = !ras_empty;
                    pred_target = ras_top;
                end
            endcase
        end
    end

    always_comb begin
        bp_valid_d  = bp_valid_q;
        bp_taken_d  = bp_taken_q;
        bp_target_d = bp_target_q;
        if (bus.flush) begin
            bp_valid_d  = 1'b0;
            bp_taken_d  = 1'b0;
            bp_target_d = '0;
        end else if (!bus.stall) begin
            bp_valid_d  = bus.pf_valid;
            bp_taken_d  = bus.pf_valid && pred_taken;
            bp_target_d = (bus.pf_valid && pred_taken) ? pred_target : '0;
        end
    end

    // Lookup reads the _q arrays, so a same-cycle update to its index is not bypassed
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        tgt_d   = tgt_q;
        type_d  = type_q;
        ctr_d   = ctr_q;
        if (bus.upd_valid) begin
            if (up_hit) begin
                ctr_d[up_idx] = ctr_next(ctr_q[up_idx], bus.upd_taken);
                if (bus.upd_taken) begin
                    tgt_d[up_idx]  = bus.upd_target[31:2];
                    type_d[up_idx] = up_type;
                end
            end else if (bus.upd_taken) begin
                valid_d[up_idx] = 1'b1;
                tag_d[up_idx]   = up_tag;
                tgt_d[up_idx]   = bus.upd_target[31:2];
                type_d[up_idx]  = up_type;
                ctr_d[up_idx]   = (up_type == BR_COND) ? CTR_WT : CTR_ST;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            valid_q     <= '{default: 1'b0};
            tag_q       <= '{default: '0};
            tgt_q       <= '{default: '0};
            type_q      <= '{default: BR_COND};
            ctr_q       <= '{default: CTR_WNT};
            bp_valid_q  <= 1'b0;
            bp_taken_q  <= 1'b0;
            bp_target_q <= '0;
        end else begin
            valid_q     <= valid_d;
            tag_q       <= tag_d;
            tgt_q       <= tgt_d;
            type_q      <= type_d;
            ctr_q       <= ctr_d;
            bp_valid_q  <= bp_valid_d;
            bp_taken_q  <= bp_taken_d;
            bp_target_q <= bp_target_d;
        end
    end

    assign bus.bp_valid  = bp_valid_q;
    assign bus.bp_taken  = bp_taken_q;
    assign bus.bp_target = bp_target_q;

endmodule

// File: tb/tb_branch_target_predictor.sv
// tb/tb_branch_target_predictor.sv - directed and randomized checks against a behavioural predictor model
module tb_branch_target_predictor;

    localparam int ENT = 64;
    localparam int DEP = 8;

    logic aclk;
    logic aresetn;

    branch_target_predictor_if bus();

    branch_target_predictor dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int tests;
    int fails;

    bit          m_valid [ENT];
    int          m_tag   [ENT];
    logic [31:0] m_tgt   [ENT];
    int          m_type  [ENT];
    int          m_ctr   [ENT];
    logic [31:0] m_ras   [DEP];
    int          sp, cnt, csp, ccnt;
    logic        ex_valid, ex_taken;
    logic [31:0] ex_target;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % ENT);
    endfunction

    function automatic int tag_of(input logic [31:0] pc);
        return int'((pc >> 8) % 256);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < ENT; i++) begin
            m_valid[i] = 1'b0; m_tag[i] = 0; m_tgt[i] = '0; m_type[i] = 0; m_ctr[i] = 1;
        end
        for (int i = 0; i < DEP; i++) m_ras[i] = '0;
        sp = 0; cnt = 0; csp = 0; ccnt = 0;
        ex_valid = 1'b0; ex_taken = 1'b0; ex_target = '0;
    endtask

    task automatic model_cycle();
        int          i, u;
        bit          hit, uhit;
        logic        tk;
        logic [31:0] tg;
        i   = idx_of(bus.pf_pc);
        hit = m_valid[i] && (m_tag[i] == tag_of(bus.pf_pc));
        if (bus.flush) begin
            ex_valid = 1'b0; ex_taken = 1'b0; ex_target = '0;
        end else if (!bus.stall) begin
            tk = 1'b0;
            tg = '0;
            if (bus.pf_valid && hit) begin
                case (m_type[i])
                    0:       begin tk = (m_ctr[i] >= 2); tg = m_tgt[i]; end
                    1, 2:    begin tk = 1'b1; tg = m_tgt[i]; end
                    default: begin tk = (cnt > 0); tg = m_ras[(sp + DEP - 1) % DEP]; end
                endcase
                if (m_type[i] == 2) begin
                    m_ras[sp] = bus.pf_pc + 32'd8;
                    sp = (sp + 1) % DEP;
                    if (cnt < DEP) cnt++;
                end else if (m_type[i] == 3 && cnt > 0) begin
                    sp = (sp + DEP - 1) % DEP;
                    cnt--;
                end
            end
            ex_valid  = bus.pf_valid;
            ex_taken  = tk;
            ex_target = tk ? tg : 32'd0;
        end
        if (bus.upd_valid) begin
            u    = idx_of(bus.upd_pc);
            uhit = m_valid[u] && (m_tag[u] == tag_of(bus.upd_pc));
            if (uhit) begin
                m_ctr[u] = bus.upd_taken ? ((m_ctr[u] < 3) ? m_ctr[u] + 1 : 3)
                                         : ((m_ctr[u] > 0) ? m_ctr[u] - 1 : 0);
                if (bus.upd_taken) begin
                    m_tgt[u]  = bus.upd_target & 32'hFFFF_FFFC;
                    m_type[u] = int'(bus.upd_type);
                end
            end else if (bus.upd_taken) begin
                m_valid[u] = 1'b1;
                m_tag[u]   = tag_of(bus.upd_pc);
                m_tgt[u]   = bus.upd_target & 32'hFFFF_FFFC;
                m_type[u]  = int'(bus.upd_type);
                m_ctr[u]   = (bus.upd_type == 2'b00) ? 2 : 3;
            end
            if (bus.upd_type == 2'b10) begin
                csp = (csp + 1) % DEP;
                if (ccnt < DEP) ccnt++;
            end else if (bus.upd_type == 2'b11 && ccnt > 0) begin
                csp = (csp + DEP - 1) % DEP;
                ccnt--;
            end
            if (bus.upd_mispredict) begin
                sp  = csp;
                cnt = ccnt;
            end
        end
    endtask

    task automatic step();
        model_cycle();
        @(posedge aclk);
        #1;
        check("bp_valid", {31'd0, bus.bp_valid}, {31'd0, ex_valid});
        check("bp_taken", {31'd0, bus.bp_taken}, {31'd0, ex_taken});
        check("bp_target", bus.bp_target, ex_target);
    endtask

    task automatic idle();
        bus.pf_valid = 1'b0; bus.pf_pc = '0; bus.stall = 1'b0; bus.flush = 1'b0;
        bus.upd_valid = 1'b0; bus.upd_pc = '0; bus.upd_type = 2'b00;
        bus.upd_taken = 1'b0; bus.upd_target = '0; bus.upd_mispredict = 1'b0;
    endtask

    task automatic lookup(input logic [31:0] pc);
        bus.pf_valid = 1'b1;
        bus.pf_pc    = pc;
    endtask

    task automatic upd(input logic [31:0] pc, input logic [1:0] ty, input logic tk,
                       input logic [31:0] tgt, input logic misp);
        bus.upd_valid      = 1'b1;
        bus.upd_pc         = pc;
        bus.upd_type       = ty;
        bus.upd_taken      = tk;
        bus.upd_target     = tgt;
        bus.upd_mispredict = misp;
    endtask

    function automatic logic [31:0] rand_pc();
        return 32'hBFC0_0000 | 32'($urandom_range(0, 7) << 2) | 32'($urandom_range(0, 1) << 8);
    endfunction

    initial begin
        tests = 0;
        fails = 0;
        idle();
        aresetn = 1'b0;
        model_reset();
        repeat (2) @(posedge aclk);
        #1;
        check("rst_valid", {31'd0, bus.bp_valid}, 32'd0);
        check("rst_taken", {31'd0, bus.bp_taken}, 32'd0);
        check("rst_target", bus.bp_target, 32'd0);
        aresetn = 1'b1;

        lookup(32'hBFC0_0000); step();
        check("miss_valid", {31'd0, bus.bp_valid}, 32'd1);
        check("miss_taken", {31'd0, bus.bp_taken}, 32'd0);
        check("miss_target", bus.bp_target, 32'd0);

        idle(); upd(32'hBFC0_0010, 2'b00, 1'b1, 32'hBFC0_0100, 1'b0); step();
        idle(); lookup(32'hBFC0_0010); step();
        check("cond_taken", {31'd0, bus.bp_taken}, 32'd1);
        check("cond_target", bus.bp_target, 32'hBFC0_0100);
        idle(); upd(32'hBFC0_0010, 2'b00, 1'b0, 32'd0, 1'b0); step(); step();
        idle(); lookup(32'hBFC0_0010); step();
        check("cond_nt_taken", {31'd0, bus.bp_taken}, 32'd0);
        check("cond_nt_target", bus.bp_target, 32'd0);

        idle(); upd(32'hBFC0_0020, 2'b10, 1'b1, 32'hBFC0_0400, 1'b0); step();
        upd(32'hBFC0_0030, 2'b11, 1'b1, 32'd0, 1'b0); step();
        idle(); lookup(32'hBFC0_0020); step();
        check("call_taken", {31'd0, bus.bp_taken}, 32'd1);
        check("call_target", bus.bp_target, 32'hBFC0_0400);
        lookup(32'hBFC0_0030); step();
        check("ret_taken", {31'd0, bus.bp_taken}, 32'd1);
        check("ret_target", bus.bp_target, 32'hBFC0_0028);
        step();
        check("ret_empty_taken", {31'd0, bus.bp_taken}, 32'd0);

        idle();
        for (int i = 0; i < 9; i++) begin
            upd(32'hBFC0_0040 + 32'(4 * i), 2'b10, 1'b1, 32'hBFC0_0800, 1'b0); step();
        end
        idle();
        for (int i = 0; i < 9; i++) begin
            lookup(32'hBFC0_0040 + 32'(4 * i)); step();
        end
        for (int k = 0; k < 9; k++) begin
            lookup(32'hBFC0_0030); step();
            if (k < 8) begin
                check("ras_pop_target", bus.bp_target, 32'hBFC0_0048 + 32'(4 * (8 - k)));
            end else begin
                check("ras_underflow_taken", {31'd0, bus.bp_taken}, 32'd0);
            end
        end

        idle();
        for (int i = 0; i < 8; i++) begin
            upd(32'hBFC0_0030, 2'b11, 1'b1, 32'd0, 1'b0); step();
        end
        idle(); lookup(32'hBFC0_0020); step();
        idle(); upd(32'hBFC0_0090, 2'b00, 1'b0, 32'd0, 1'b1); step();
        idle(); lookup(32'hBFC0_0030); step();
        check("recover_taken", {31'd0, bus.bp_taken}, 32'd0);

        idle(); lookup(32'hBFC0_0080); upd(32'hBFC0_0080, 2'b00, 1'b1, 32'hBFC0_0200, 1'b0); step();
        check("same_cycle_taken", {31'd0, bus.bp_taken}, 32'd0);
        idle(); lookup(32'hBFC0_0080); step();
        check("after_update_taken", {31'd0, bus.bp_taken}, 32'd1);
        check("after_update_target", bus.bp_target, 32'hBFC0_0200);

        bus.stall = 1'b1; lookup(32'hBFC0_0000);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_valid", {31'd0, bus.bp_valid}, 32'd1);
            check("stall_target", bus.bp_target, 32'hBFC0_0200);
        end

        idle(); lookup(32'hBFC0_0080); bus.flush = 1'b1; step();
        check("flush_valid", {31'd0, bus.bp_valid}, 32'd0);

        idle(); lookup(32'hBFC0_0080); step();
        #2 aresetn = 1'b0;
        model_reset();
        #1;
        check("midrst_valid", {31'd0, bus.bp_valid}, 32'd0);
        check("midrst_taken", {31'd0, bus.bp_taken}, 32'd0);
        check("midrst_target", bus.bp_target, 32'd0);
        #2 aresetn = 1'b1;
        step();
        check("post_rst_taken", {31'd0, bus.bp_taken}, 32'd0);

        for (int n = 0; n < 400; n++) begin
            idle();
            bus.pf_valid = ($urandom_range(0, 3) != 0);
            bus.pf_pc    = rand_pc();
            bus.stall    = ($urandom_range(0, 7) == 0);
            bus.flush    = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 1) == 1) begin
                upd(rand_pc(), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    $urandom() & 32'hFFFF_FFFC, ($urandom_range(0, 7) == 0));
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
